// File: rtl/sha256_msg_scheduler.sv
// SHA-256 message scheduler: loads 16 words, then serves W[0..63] one per STN rising edge,
// computing W[16..63] in place in a 16-entry circular buffer. Optional macro: SCHED_OVERRUN_CHECK_EN.
module sha256_msg_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        load_valid,
  input  logic [31:0] load_word,
  output logic        load_ready,
  input  logic        STN,
  output logic [31:0] Wt_out,
  output logic        Wt_valid,
  output logic [5:0]  t_index,
  output logic        busy,
  output logic        done
`ifdef SCHED_OVERRUN_CHECK_EN
  ,
  output logic        sched_err
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_READY  = 3'd2;
  localparam logic [2:0] S_CALC1  = 3'd3;
  localparam logic [2:0] S_CALC2  = 3'd4;
  localparam logic [2:0] S_CALC3  = 3'd5;
  localparam logic [2:0] S_COMMIT = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]  state_q, state_d;
  logic [31:0] buf_q [16];
  logic [31:0] buf_d [16];
  logic [31:0] wt_q, wt_d;
  logic [31:0] acc_q, acc_d;
  logic [5:0]  t_q, t_d;
  logic [3:0]  wr_cnt_q, wr_cnt_d;
  logic        stn_q, stn_d;
  logic        wt_vld_q, wt_vld_d;

  logic        rise;
  logic [5:0]  n;
  logic [3:0]  n4;
  logic        big;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign rise = STN & ~stn_q;
  assign n    = t_q + 6'd1;
  assign n4   = n[3:0];
  assign big  = |n[5:4];

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    wt_d     = wt_q;
    acc_d    = acc_q;
    t_d      = t_q;
    wr_cnt_d = wr_cnt_q;
    wt_vld_d = wt_vld_q;
    stn_d    = STN;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          wr_cnt_d = 4'd0;
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          buf_d[wr_cnt_q] = load_word;
          wr_cnt_d        = wr_cnt_q + 4'd1;
          if (wr_cnt_q == 4'd15) begin
            wt_d     = buf_q[0];
            t_d      = 6'd0;
            wt_vld_d = 1'b1;
            state_d  = S_READY;
          end
        end
      end
      S_READY: begin
        if (rise) state_d = (t_q == 6'd63) ? S_DONE : S_CALC1;
      end
      // Buffer slot offsets from n: -2 -> +14, -7 -> +9, -15 -> +1, -16 -> +0 (mod 16).
      S_CALC1: begin
        if (big) acc_d = sig1(buf_q[n4 + 4'd14]) + buf_q[n4 + 4'd9];
        state_d = S_CALC2;
      end
      S_CALC2: begin
        if (big) acc_d = acc_q + sig0(buf_q[n4 + 4'd1]);
        state_d = S_CALC3;
      end
      S_CALC3: begin
        acc_d   = big ? (acc_q + buf_q[n4]) : buf_q[n4];
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        buf_d[n4] = acc_q;
        wt_d      = acc_q;
        t_d       = n;
        state_d   = S_READY;
      end
      S_DONE: begin
        wt_vld_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < 16; i++) buf_q[i] <= 32'd0;
      wt_q     <= 32'd0;
      acc_q    <= 32'd0;
      t_q      <= 6'd0;
      wr_cnt_q <= 4'd0;
      stn_q    <= 1'b0;
      wt_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      wt_q     <= wt_d;
      acc_q    <= acc_d;
      t_q      <= t_d;
      wr_cnt_q <= wr_cnt_d;
      stn_q    <= stn_d;
      wt_vld_q <= wt_vld_d;
    end
  end

  assign load_ready = (state_q == S_LOAD);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign Wt_out     = wt_q;
  assign Wt_valid   = wt_vld_q;
  assign t_index    = t_q;

`ifdef SCHED_OVERRUN_CHECK_EN
  logic err_q, err_d;

  // Sticky: STN edge while not waiting for one, or a restart attempt mid-block.
  always_comb begin
    err_d = err_q | (busy & rise & (state_q != S_READY)) | (busy & start);
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign sched_err = err_q;
`endif

endmodule

// File: tb/tb_sha256_msg_scheduler.sv
// Self-checking bench for sha256_msg_scheduler against a plain-arithmetic SHA-256 schedule model.
module tb_sha256_msg_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_word = 32'd0;
  logic        load_ready;
  logic        STN = 1'b0;
  logic [31:0] Wt_out;
  logic        Wt_valid;
  logic [5:0]  t_index;
  logic        busy;
  logic        done;
`ifdef SCHED_OVERRUN_CHECK_EN
  logic        sched_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] blk  [16];
  logic [31:0] wexp [64];

  always #5 clk = ~clk;

  sha256_msg_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_valid (load_valid),
    .load_word  (load_word),
    .load_ready (load_ready),
    .STN        (STN),
    .Wt_out     (Wt_out),
    .Wt_valid   (Wt_valid),
    .t_index    (t_index),
    .busy       (busy),
    .done       (done)
`ifdef SCHED_OVERRUN_CHECK_EN
    ,
    .sched_err  (sched_err)
`endif
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int r);
    return (x >> r) | (x << (32 - r));
  endfunction

  function automatic logic [31:0] ms0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ms1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function void build_model();
    for (int t = 0; t < 16; t++) wexp[t] = blk[t];
    for (int t = 16; t < 64; t++)
      wexp[t] = ms1(wexp[t-2]) + wexp[t-7] + ms0(wexp[t-15]) + wexp[t-16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; load_valid = 1'b0; STN = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic rand_block();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    build_model();
  endtask

  task automatic start_and_load();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b1; load_word = blk[i]; tick();
    end
    load_valid = 1'b0;
  endtask

  // STN high 4 cycles, low 4; lat = cycles from the sampling edge to the index change.
  task automatic pulse_stn(output int lat);
    logic [5:0] old_t;
    old_t = t_index;
    lat = 0;
    STN = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 4) STN = 1'b0;
      if (lat == 0 && t_index != old_t) lat = i - 1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({Wt_out, t_index, Wt_valid, busy, done, load_ready} !== 42'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got Wt=%h t=%0d vld=%b busy=%b done=%b rdy=%b exp all 0",
               Wt_out, t_index, Wt_valid, busy, done, load_ready);
    end
`ifdef SCHED_OVERRUN_CHECK_EN
    n_tests++;
    if (sched_err !== 1'b0) begin n_fail++; $display("FAIL reset_sched_err got %b exp 0", sched_err); end
`endif
  endtask

  task automatic test_abc();
    int lat;
    do_reset();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0] = 32'h61626380; blk[15] = 32'h00000018;
    build_model();
    start_and_load();
    n_tests++;
    if (Wt_out !== 32'h61626380 || t_index !== 6'd0 || Wt_valid !== 1'b1 || load_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abc_loaded got Wt=%h t=%0d vld=%b rdy=%b exp 61626380 0 1 0",
               Wt_out, t_index, Wt_valid, load_ready);
    end
    // Words offered outside the load phase must not touch the buffer.
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_word = $urandom; tick();
    end
    load_valid = 1'b0;
    for (int t = 1; t < 64; t++) begin
      pulse_stn(lat);
      n_tests++;
      if (lat != 4 || Wt_out !== wexp[t] || t_index !== t[5:0]) begin
        n_fail++;
        $display("FAIL abc_w%0d got Wt=%h t=%0d lat=%0d exp Wt=%h lat=4", t, Wt_out, t_index, lat, wexp[t]);
      end
      if (t == 15 || t == 16 || t == 17 || t == 63) begin
        logic [31:0] k;
        k = (t == 15) ? 32'h00000018 : (t == 16) ? 32'h61626380 :
            (t == 17) ? 32'h000F0000 : 32'h12B1EDEB;
        n_tests++;
        if (Wt_out !== k) begin
          n_fail++;
          $display("FAIL abc_known_w%0d got %h exp %h", t, Wt_out, k);
        end
      end
    end
    STN = 1'b1; tick();
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL abc_done_pulse got done=%b busy=%b exp 1 1", done, busy);
    end
    start = 1'b1; tick(); start = 1'b0;
    n_tests++;
    if (done !== 1'b0 || Wt_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abc_after_done got done=%b vld=%b busy=%b rdy=%b exp 0 0 0 0", done, Wt_valid, busy, load_ready);
    end
    tick(); STN = 1'b0; tick();
    n_tests++;
    if (load_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abc_start_at_done got rdy=%b busy=%b exp 0 0", load_ready, busy);
    end
  endtask

  task automatic test_load_gaps();
    int lat;
    do_reset();
    rand_block();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        n_tests++;
        if (Wt_valid !== 1'b0 || load_ready !== 1'b1) begin
          n_fail++; $display("FAIL gaps_before_16 got vld=%b rdy=%b exp 0 1", Wt_valid, load_ready);
        end
      end
      load_valid = 1'b1; load_word = blk[i]; tick();
      load_valid = 1'b0; load_word = $urandom; tick();
    end
    n_tests++;
    if (Wt_out !== blk[0] || Wt_valid !== 1'b1 || t_index !== 6'd0 || load_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps_loaded got Wt=%h vld=%b t=%0d rdy=%b exp %h 1 0 0", Wt_out, Wt_valid, t_index, load_ready, blk[0]);
    end
    for (int t = 1; t <= 17; t++) begin
      pulse_stn(lat);
      n_tests++;
      if (lat != 4 || Wt_out !== wexp[t] || t_index !== t[5:0]) begin
        n_fail++;
        $display("FAIL gaps_w%0d got Wt=%h t=%0d lat=%0d exp %h", t, Wt_out, t_index, lat, wexp[t]);
      end
    end
  endtask

  task automatic test_stn_hold();
    int lat;
    do_reset();
    rand_block();
    start_and_load();
    STN = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    STN = 1'b0; tick();
    n_tests++;
    if (t_index !== 6'd1 || Wt_out !== wexp[1]) begin
      n_fail++; $display("FAIL hold_one_advance got t=%0d Wt=%h exp 1 %h", t_index, Wt_out, wexp[1]);
    end
`ifdef SCHED_OVERRUN_CHECK_EN
    n_tests++;
    if (sched_err !== 1'b0) begin n_fail++; $display("FAIL hold_no_err got %b exp 0", sched_err); end
`endif
    STN = 1'b1; tick();
    STN = 1'b0; tick();
    STN = 1'b1; tick();
    STN = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    n_tests++;
    if (t_index !== 6'd2 || Wt_out !== wexp[2]) begin
      n_fail++; $display("FAIL calc2_rise_dropped got t=%0d Wt=%h exp 2 %h", t_index, Wt_out, wexp[2]);
    end
`ifdef SCHED_OVERRUN_CHECK_EN
    n_tests++;
    if (sched_err !== 1'b1) begin n_fail++; $display("FAIL calc2_sched_err got %b exp 1", sched_err); end
`endif
    start = 1'b1; tick(); start = 1'b0; tick();
    n_tests++;
    if (load_ready !== 1'b0 || t_index !== 6'd2 || Wt_valid !== 1'b1) begin
      n_fail++; $display("FAIL start_while_busy got rdy=%b t=%0d vld=%b exp 0 2 1", load_ready, t_index, Wt_valid);
    end
    pulse_stn(lat);
    n_tests++;
    if (lat != 4 || Wt_out !== wexp[3] || t_index !== 6'd3) begin
      n_fail++; $display("FAIL hold_resume got Wt=%h t=%0d lat=%0d exp %h 3 4", Wt_out, t_index, lat, wexp[3]);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    do_reset();
    rand_block();
    start_and_load();
    for (int t = 1; t <= 30; t++) pulse_stn(lat);
    n_tests++;
    if (t_index !== 6'd30 || Wt_out !== wexp[30]) begin
      n_fail++; $display("FAIL mid_reach_30 got t=%0d Wt=%h exp 30 %h", t_index, Wt_out, wexp[30]);
    end
    STN = 1'b1; tick(); tick();
    rst = 1'b1; STN = 1'b0; tick(); rst = 1'b0;
    n_tests++;
    if (Wt_out !== 32'd0 || t_index !== 6'd0 || busy !== 1'b0 || Wt_valid !== 1'b0 || load_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset got Wt=%h t=%0d busy=%b vld=%b rdy=%b exp 0", Wt_out, t_index, busy, Wt_valid, load_ready);
    end
    rand_block();
    start_and_load();
    n_tests++;
    if (Wt_out !== blk[0] || Wt_valid !== 1'b1 || t_index !== 6'd0) begin
      n_fail++; $display("FAIL mid_reload got Wt=%h vld=%b t=%0d exp %h 1 0", Wt_out, Wt_valid, t_index, blk[0]);
    end
    for (int t = 1; t <= 18; t++) begin
      pulse_stn(lat);
      n_tests++;
      if (lat != 4 || Wt_out !== wexp[t]) begin
        n_fail++; $display("FAIL mid_reload_w%0d got Wt=%h lat=%0d exp %h", t, Wt_out, lat, wexp[t]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_reset();
    for (int b = 0; b < 2; b++) begin
      rand_block();
      start_and_load();
      n_tests++;
      if (Wt_out !== wexp[0] || Wt_valid !== 1'b1) begin
        n_fail++; $display("FAIL b2b%0d_w0 got Wt=%h vld=%b exp %h 1", b, Wt_out, Wt_valid, wexp[0]);
      end
      for (int t = 1; t < 64; t++) begin
        pulse_stn(lat);
        n_tests++;
        if (lat != 4 || Wt_out !== wexp[t] || t_index !== t[5:0]) begin
          n_fail++;
          $display("FAIL b2b%0d_w%0d got Wt=%h t=%0d lat=%0d exp %h", b, t, Wt_out, t_index, lat, wexp[t]);
        end
      end
      STN = 1'b1; tick();
      n_tests++;
      if (done !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_done got %b exp 1", b, done); end
      tick(); STN = 1'b0;
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0 || Wt_valid !== 1'b0) begin
        n_fail++; $display("FAIL b2b%0d_idle got done=%b busy=%b vld=%b exp 0 0 0", b, done, busy, Wt_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_load_gaps();
    test_stn_hold();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
